decimal_key_encoder: RTL and testbench



---
 rtl/decimal_key_encoder.sv | 206 ++++++++++++++++++++
 tb/tb_decimal_key_encoder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/decimal_key_encoder.sv
// decimal_key_encoder: turns ten raw one-of-ten keypad lines into debounced
// BCD digit codes, delivered over a valid/ready handshake with a 1-deep
// output register. Multi-key patterns are emitted as 4'hF with out_err set.
// Optional auto-repeat while a key is held: define DECIMAL_KEY_REPEAT_EN.
module decimal_key_encoder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 256,
  parameter int REPEAT_PERIOD   = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] key,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] out_bcd,
  output logic       out_err,
  output logic       overrun,
  input  logic       overrun_clr,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [15:0] DB_LIM = 16'(DEBOUNCE_CYCLES);

  // Counters are 16 bits wide, so every cycle-count parameter must fit.
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 ||
      REPEAT_DELAY < 1 || REPEAT_DELAY > 65535 ||
      REPEAT_PERIOD < 1 || REPEAT_PERIOD > 65535) begin : g_badParams
    $error("decimal_key_encoder: cycle-count parameter out of range");
  end

  state_t      r_state;
  state_t      w_next;
  logic [9:0]  r_sync1;
  logic [9:0]  r_sync2;
  logic [9:0]  r_cap;
  logic [9:0]  w_capNext;
  logic [15:0] r_cnt;
  logic [15:0] w_cntNext;
  logic        w_emit;
  logic [3:0]  w_hotCount;
  logic [3:0]  w_hotIndex;
  logic [3:0]  w_code;
  logic        w_codeErr;
  logic        r_valid;
  logic [3:0]  r_bcd;
  logic        r_err;
  logic        r_overrun;
  logic        r_busy;

`ifdef DECIMAL_KEY_REPEAT_EN
  localparam logic [15:0] RPT_DLY = 16'(REPEAT_DELAY);
  localparam logic [15:0] RPT_PER = 16'(REPEAT_PERIOD);

  logic [15:0] r_rptCnt;
  logic        r_rptSteady;
  logic        w_rptEmit;

  assign w_rptEmit = (r_state == HELD) && (r_sync2 != 10'd0) &&
                     (r_rptCnt == (r_rptSteady ? RPT_PER : RPT_DLY));

  // Repeat timer: restarts on every HELD entry and after each repeat emit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rptCnt    <= 16'd0;
      r_rptSteady <= 1'b0;
    end else if (w_rptEmit || (w_next == HELD && r_state != HELD)) begin
      r_rptCnt    <= 16'd1;
      r_rptSteady <= w_rptEmit;
    end else if (r_state == HELD) begin
      r_rptCnt <= r_rptCnt + 16'd1;
    end
  end
`endif

  // Two-flop synchronizer; the raw key lines are asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 10'd0;
      r_sync2 <= 10'd0;
    end else begin
      r_sync1 <= key;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce state register with the captured pattern and cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cap   <= 10'd0;
      r_cnt   <= 16'd0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cap   <= w_capNext;
      r_cnt   <= w_cntNext;
      r_busy  <= (w_next != IDLE);
    end
  end

  // Next-state logic: a pattern must hold still to be accepted, and a full
  // quiet period must follow before the next press is recognised.
  always_comb begin
    w_next    = r_state;
    w_capNext = r_cap;
    w_cntNext = r_cnt;
    w_emit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_sync2 != 10'd0) begin
          w_capNext = r_sync2;
          w_cntNext = 16'd1;
          w_next    = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (r_sync2 == 10'd0) begin
          w_next = IDLE;
        end else if (r_sync2 != r_cap) begin
          w_capNext = r_sync2;
          w_cntNext = 16'd1;
        end else if (r_cnt == DB_LIM) begin
          w_emit = 1'b1;
          w_next = HELD;
        end else begin
          w_cntNext = r_cnt + 16'd1;
        end
      end
      HELD: begin
        if (r_sync2 == 10'd0) begin
          w_cntNext = 16'd1;
          w_next    = RELEASE;
        end
`ifdef DECIMAL_KEY_REPEAT_EN
        else if (w_rptEmit) begin
          w_emit = 1'b1;
        end
`endif
      end
      RELEASE: begin
        if (r_sync2 != 10'd0) begin
          w_next = HELD;
        end else if (r_cnt == DB_LIM) begin
          w_next = IDLE;
        end else begin
          w_cntNext = r_cnt + 16'd1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Encode the captured pattern: one-hot gives its index, anything else 4'hF.
  always_comb begin
    w_hotCount = 4'd0;
    w_hotIndex = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (r_cap[i]) begin
        w_hotCount = w_hotCount + 4'd1;
        w_hotIndex = 4'(i);
      end
    end
    w_codeErr = (w_hotCount != 4'd1);
    w_code    = w_codeErr ? 4'hF : w_hotIndex;
  end

  // Output register: load on emit if empty or being drained, else drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_bcd   <= 4'd0;
      r_err   <= 1'b0;
    end else if (w_emit && (!r_valid || out_ready)) begin
      r_valid <= 1'b1;
      r_bcd   <= w_code;
      r_err   <= w_codeErr;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Sticky overrun flag; a new drop wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_emit && r_valid && !out_ready) begin
      r_overrun <= 1'b1;
    end else if (overrun_clr) begin
      r_overrun <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_bcd   = r_bcd;
  assign out_err   = r_err;
  assign overrun   = r_overrun;
  assign busy      = r_busy;

endmodule

// File: tb/tb_decimal_key_encoder.sv
// Testbench for decimal_key_encoder: directed scenarios plus randomized key
// activity, checked by a scoreboard fed from a run-length reference model.
module tb_decimal_key_encoder;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  typedef struct {
    logic [3:0] bcd;
    logic       err;
  } code_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] key;
  logic       out_ready;
  logic       overrun_clr;
  logic       out_valid;
  logic [3:0] out_bcd;
  logic       out_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int passes = 0;

  // Reference model state: key pipeline, run lengths, output-register image.
  logic [9:0] m1, m2, mP, prevP;
  int         runLen, zeroRun, heldCnt, nextAt;
  bit         armed, mPending, mOverrun, mEmit;
  code_t      mCode, heldCode, monExp;
  code_t      expQ[$];

  always #5 clk = ~clk;

  decimal_key_encoder #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key(key),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_bcd(out_bcd),
    .out_err(out_err),
    .overrun(overrun),
    .overrun_clr(overrun_clr),
    .busy(busy)
  );

  function automatic code_t encodeRef(input logic [9:0] pat);
    code_t c;
    c.bcd = 4'hF;
    c.err = 1'b1;
    if ($countones(pat) == 1) begin
      for (int i = 0; i < 10; i++) begin
        if (pat == (10'd1 << i)) begin
          c.bcd = 4'(i);
          c.err = 1'b0;
        end
      end
    end
    return c;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input logic [9:0] k, input int cycles,
                               input logic rdy, input logic clr);
    key         = k;
    out_ready   = rdy;
    overrun_clr = clr;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Reference model: a press is accepted once the same nonzero pattern has
  // been seen DB+1 edges in a row; re-arming needs DB+1 quiet edges.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1 = 10'd0; m2 = 10'd0; prevP = 10'd0;
      runLen = 0; zeroRun = 0; heldCnt = 0; nextAt = RD;
      armed = 1'b1; mPending = 1'b0; mOverrun = 1'b0;
      expQ.delete();
    end else begin
      mP = m2; m2 = m1; m1 = key;
      mEmit = 1'b0;
      if (armed) begin
        if (mP == 10'd0) runLen = 0;
        else if (runLen > 0 && mP == prevP) runLen++;
        else runLen = 1;
        if (runLen == DB + 1) begin
          mEmit = 1'b1; mCode = encodeRef(mP); heldCode = mCode;
          armed = 1'b0; runLen = 0; zeroRun = 0; heldCnt = 0; nextAt = RD;
        end
      end else if (mP == 10'd0) begin
        zeroRun++; heldCnt = 0; nextAt = RD;
        if (zeroRun == DB + 1) armed = 1'b1;
      end else if (zeroRun > 0) begin
        zeroRun = 0; heldCnt = 0;
      end else begin
`ifdef DECIMAL_KEY_REPEAT_EN
        heldCnt++;
        if (heldCnt == nextAt) begin
          mEmit = 1'b1; mCode = heldCode; heldCnt = 0; nextAt = RP;
        end
`endif
      end
      prevP = mP;
      if (mEmit && mPending && !out_ready) mOverrun = 1'b1;
      else if (overrun_clr) mOverrun = 1'b0;
      if (mEmit && (!mPending || out_ready)) begin
        expQ.push_back(mCode);
        mPending = 1'b1;
      end else if (mPending && out_ready) begin
        mPending = 1'b0;
      end
    end
  end

  // Monitor: compare flags every cycle and pop the scoreboard on handshakes.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("out_valid", int'(out_valid), int'(mPending));
      checkOutput("overrun", int'(overrun), int'(mOverrun));
      checkOutput("busy", int'(busy), int'(!(armed && runLen == 0)));
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected code", int'(out_bcd), -1);
        end else begin
          monExp = expQ.pop_front();
          checkOutput("out_bcd", int'(out_bcd), int'(monExp.bcd));
          checkOutput("out_err", int'(out_err), int'(monExp.err));
        end
      end
    end
  end

  initial begin
    int sel, a, b, len;
    logic [9:0] k;
    rst_n = 1'b0; key = 10'd0; out_ready = 1'b1; overrun_clr = 1'b0;
    #1;
    checkOutput("reset out_valid", int'(out_valid), 0);
    checkOutput("reset out_bcd", int'(out_bcd), 0);
    checkOutput("reset out_err", int'(out_err), 0);
    checkOutput("reset overrun", int'(overrun), 0);
    checkOutput("reset busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(10'h000, 3, 1'b1, 1'b0);

    $display("[TB] single key 3, latency and release timing");
    applyStimulus(10'h008, 6, 1'b1, 1'b0);
    checkOutput("latency edge 6", int'(out_valid), 0);
    applyStimulus(10'h008, 1, 1'b1, 1'b0);
    checkOutput("latency edge 7", int'(out_valid), 1);
    checkOutput("first bcd", int'(out_bcd), 3);
    applyStimulus(10'h008, 23, 1'b1, 1'b0);
    applyStimulus(10'h000, 6, 1'b1, 1'b0);
    checkOutput("busy before quiet", int'(busy), 1);
    applyStimulus(10'h000, 1, 1'b1, 1'b0);
    checkOutput("busy after quiet", int'(busy), 0);
    applyStimulus(10'h000, 5, 1'b1, 1'b0);

    $display("[TB] bouncing key 9");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(10'h200, 2, 1'b1, 1'b0);
      applyStimulus(10'h000, 2, 1'b1, 1'b0);
    end
    applyStimulus(10'h200, 15, 1'b1, 1'b0);
    applyStimulus(10'h000, 12, 1'b1, 1'b0);

    $display("[TB] multi-key and held-pattern change");
    applyStimulus(10'h003, 12, 1'b1, 1'b0);
    applyStimulus(10'h000, 12, 1'b1, 1'b0);
    applyStimulus(10'h001, 10, 1'b1, 1'b0);
    applyStimulus(10'h003, 10, 1'b1, 1'b0);
    applyStimulus(10'h000, 12, 1'b1, 1'b0);

    $display("[TB] overrun with consumer stalled");
    applyStimulus(10'h020, 10, 1'b0, 1'b0);
    applyStimulus(10'h000, 10, 1'b0, 1'b0);
    applyStimulus(10'h080, 10, 1'b0, 1'b0);
    applyStimulus(10'h000, 10, 1'b0, 1'b0);
    checkOutput("stalled bcd", int'(out_bcd), 5);
    checkOutput("overrun set", int'(overrun), 1);
    applyStimulus(10'h000, 1, 1'b1, 1'b0);
    checkOutput("drained valid", int'(out_valid), 0);
    applyStimulus(10'h000, 1, 1'b1, 1'b1);
    checkOutput("overrun cleared", int'(overrun), 0);
    applyStimulus(10'h000, 3, 1'b1, 1'b0);

    $display("[TB] reset during debounce");
    applyStimulus(10'h010, 4, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset busy", int'(busy), 0);
    checkOutput("midreset out_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(10'h010, 6, 1'b1, 1'b0);
    checkOutput("post-reset edge 6", int'(out_valid), 0);
    applyStimulus(10'h010, 1, 1'b1, 1'b0);
    checkOutput("post-reset edge 7", int'(out_valid), 1);
    checkOutput("post-reset bcd", int'(out_bcd), 4);
    applyStimulus(10'h000, 12, 1'b1, 1'b0);

    $display("[TB] randomized key activity");
    for (int n = 0; n < 250; n++) begin
      sel = int'($urandom_range(0, 9));
      a   = int'($urandom_range(0, 9));
      b   = int'($urandom_range(0, 9));
      if (sel < 3) k = 10'd0;
      else if (sel < 8) k = 10'd1 << a;
      else k = (10'd1 << a) | (10'd1 << b);
      len = int'($urandom_range(1, 14));
      applyStimulus(k, len, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
    end
    applyStimulus(10'h000, 20, 1'b1, 1'b0);
    checkOutput("scoreboard drained", expQ.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
